zigzag_scan_pp: RTL and testbench
=================================

Name: zigzag_scan_pp

Overview:
Parametrised N x N block reorder engine for the transform/entropy-coding path. Accepts one block of N*N samples in row-major order and emits it in zigzag, raster or transposed order. Two internal ping-pong banks allow block k+1 to be written while block k is read, giving sustained one-sample-per-cycle throughput. Valid/ready handshakes are used on both sides.

Parameters:
DATA_WIDTH, 10, sample width in bits
LOG2_N, 3, log2 of block edge; N = 2**LOG2_N, block = N*N samples (legal range 1..5)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; discards all stored and partial blocks
in_valid  in  1  input sample valid
in_ready  out  1  engine can accept a sample
in_data  in  DATA_WIDTH  sample; row-major position = input count within block
in_mode  in  2  scan mode; sampled on the first handshake of each block
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  reordered sample
out_last  out  1  high with the final (N*N-th) sample of a block
busy  out  1  any bank not EMPTY or output register occupied

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk. Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0. Both banks are EMPTY; all counters and pointers are 0.
- Handshake: a transfer occurs when valid && ready at a clk edge. out_valid/out_data/out_last are registered and held stable while out_valid && !out_ready. in_ready does not depend combinationally on in_valid.
- Storage: 2 banks x N*N x DATA_WIDTH with synchronous read and 1-cycle latency. Each bank has a state: EMPTY -> FILLING (first write) -> FULL (N*N-th write) -> DRAINING (first read issued) -> EMPTY (out_last handshake).
- Write side: wr_ptr selects the bank and a write counter 0..N*N-1 is the address. in_ready=1 iff the wr_ptr bank is EMPTY or FILLING. On the N*N-th write, wr_ptr toggles and the counter wraps to 0. in_mode is latched into the bank's mode register on write count 0.
- Read side: rd_ptr bank is read when it is FULL/DRAINING. Read address generator (r,c) starts at (0,0) per block. Reads advance only when the output register is empty or is being consumed in the same cycle; no sample is dropped or duplicated under any out_ready pattern.
- Modes: 00 zigzag; 01 raster (addr=r*N+c, c fastest); 10 transpose (column-major, r fastest); 11 treated as raster.
- Zigzag stepping, computed arithmetically (no lookup table), addr=r*N+c:
  - r+c even: if c==N-1 then r+1; else if r==0 then c+1; else r-1, c+1.
  - r+c odd: if r==N-1 then c+1; else if c==0 then r+1; else r+1, c-1.
- Latency: last input handshake of a block to first out_valid is 2 cycles when the read side is idle. With out_ready held 1, output is gap-free across block boundaries; rd_ptr toggles on the out_last handshake.
- Simultaneous write to one bank and read from the other in the same cycle is fully supported. The same bank is never written and read concurrently.
- Both banks FULL/DRAINING: in_ready=0 until the drained bank returns to EMPTY. in_ready rises the cycle after out_last is accepted.
- flush (synchronous) has the same effect as reset on all state and outputs; flush dominates same-cycle handshakes. Reset or flush mid-block discards partial data; the next input sample is treated as position 0.
- busy deasserts only when both banks are EMPTY and out_valid=0.

Test Plan:
1. N=8, mode 00, in_data=0..63 back-to-back, out_ready=1 -> out_data 0,1,8,16,9,2,3,10,17,24,...,55,62,63; out_last only on the 64th; first out_valid 2 cycles after the 64th input handshake.
2. Four consecutive blocks, modes 00/01/10/00, out_ready=1 -> in_ready never drops, 256 outputs with no gaps; block 2 = 0..63, block 3 = 0,8,16,...,56,1,9,...,63.
3. out_ready=0 throughout, 200 inputs offered -> exactly 128 accepted, then in_ready=0. Raise out_ready -> in_ready returns 1 the cycle after the first out_last. All data correct.
4. Random out_ready (50%) with random in_valid gaps over 20 blocks -> output matches the scoreboard model exactly, and out_data stays stable while stalled.
5. LOG2_N=2, DATA_WIDTH=12, mode 00, in 0..15 -> out 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
6. Assert rst_n low after 30 inputs, and separately pulse flush while a block is draining -> outputs return to reset values immediately (async) or next edge (flush). The next full block is reordered correctly from position 0.

Source files
------------

// File: rtl/zigzag_scan_pp.sv
// N x N block reorder engine: row-major input, zigzag/raster/transposed output.
// Two ping-pong banks let one block fill while the previous one drains.
module zigzag_scan_pp #(
  parameter int DATA_WIDTH = 10,
  parameter int LOG2_N     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int AW = 2 * LOG2_N;
  localparam int NN = 1 << AW;
  localparam logic [AW-1:0]     LAST_IDX = '1;
  localparam logic [LOG2_N-1:0] EDGE     = '1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  bank_st_t st [2];
  bank_st_t st_nxt [2];

  logic [DATA_WIDTH-1:0] mem [2][NN];
  logic [1:0]            mode_q [2];

  logic              wr_ptr, iss_ptr, rd_ptr;
  logic [AW-1:0]     wr_cnt, iss_cnt;
  logic [LOG2_N-1:0] r_p0, c_p0;
  logic [AW-1:0]     rd_addr_p0;
  logic              vld_p0, vld_p1, last_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic              wr_fire, adv, iss_ok, iss_last, release_bank;

  // Next (r,c) of the scan; zigzag walks anti-diagonals alternating direction.
  function automatic logic [AW-1:0] step_rc(input logic [1:0] mode,
                                            input logic [LOG2_N-1:0] r,
                                            input logic [LOG2_N-1:0] c);
    logic [LOG2_N-1:0] nr, nc;
    nr = r;
    nc = c;
    case (mode)
      2'b00: begin
        if ((r[0] ^ c[0]) == 1'b0) begin
          if (c == EDGE)       nr = r + 1'b1;
          else if (r == '0)    nc = c + 1'b1;
          else begin nr = r - 1'b1; nc = c + 1'b1; end
        end else begin
          if (r == EDGE)       nc = c + 1'b1;
          else if (c == '0)    nr = r + 1'b1;
          else begin nr = r + 1'b1; nc = c - 1'b1; end
        end
      end
      2'b10: begin
        if (r == EDGE) begin nr = '0; nc = c + 1'b1; end
        else nr = r + 1'b1;
      end
      default: begin
        if (c == EDGE) begin nc = '0; nr = r + 1'b1; end
        else nc = c + 1'b1;
      end
    endcase
    return {nr, nc};
  endfunction

  assign in_ready     = (st[wr_ptr] == EMPTY) || (st[wr_ptr] == FILLING);
  assign wr_fire      = in_valid && in_ready && !flush;
  assign adv          = !out_valid || out_ready;
  assign iss_ok       = (st[iss_ptr] == FULL) || (st[iss_ptr] == DRAINING);
  assign vld_p0       = adv && iss_ok && !flush;
  assign iss_last     = (iss_cnt == LAST_IDX);
  assign rd_addr_p0   = {r_p0, c_p0};
  assign release_bank = out_valid && out_ready && out_last && !flush;
  assign busy         = (st[0] != EMPTY) || (st[1] != EMPTY) || out_valid;

  always_comb begin
    st_nxt = st;
    if (wr_fire) begin
      if (wr_cnt == '0)       st_nxt[wr_ptr] = FILLING;
      if (wr_cnt == LAST_IDX) st_nxt[wr_ptr] = FULL;
    end
    if (vld_p0 && (st[iss_ptr] == FULL)) st_nxt[iss_ptr] = DRAINING;
    if (release_bank) st_nxt[rd_ptr] = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
    end else if (flush) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
    end else begin
      st <= st_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0; wr_cnt <= '0; iss_ptr <= 1'b0; iss_cnt <= '0; rd_ptr <= 1'b0;
      r_p0 <= '0; c_p0 <= '0; mode_q[0] <= 2'b00; mode_q[1] <= 2'b00;
      vld_p1 <= 1'b0; last_p1 <= 1'b0;
      out_valid <= 1'b0; out_last <= 1'b0; out_data <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0; wr_cnt <= '0; iss_ptr <= 1'b0; iss_cnt <= '0; rd_ptr <= 1'b0;
      r_p0 <= '0; c_p0 <= '0; mode_q[0] <= 2'b00; mode_q[1] <= 2'b00;
      vld_p1 <= 1'b0; last_p1 <= 1'b0;
      out_valid <= 1'b0; out_last <= 1'b0; out_data <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '0)       mode_q[wr_ptr] <= in_mode;
        if (wr_cnt == LAST_IDX) wr_ptr <= ~wr_ptr;
      end
      // p0: address generation for the bank being issued
      if (vld_p0) begin
        if (iss_last) begin
          iss_cnt <= '0; r_p0 <= '0; c_p0 <= '0; iss_ptr <= ~iss_ptr;
        end else begin
          iss_cnt <= iss_cnt + 1'b1;
          {r_p0, c_p0} <= step_rc(mode_q[iss_ptr], r_p0, c_p0);
        end
      end
      // p1 -> output register
      if (adv) begin
        vld_p1    <= vld_p0;
        last_p1   <= vld_p0 && iss_last;
        out_valid <= vld_p1;
        out_last  <= vld_p1 && last_p1;
        if (vld_p1) out_data <= rd_data_p1;
      end
      if (release_bank) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr][wr_cnt] <= in_data;
    if (vld_p0)  rd_data_p1 <= mem[iss_ptr][rd_addr_p0];
  end

endmodule

// File: tb/tb_zigzag_scan_pp.sv
// Directed bench for zigzag_scan_pp: N=8 instance for scan/flow-control tests,
// N=4 instance for the small-block zigzag order.
module tb_zigzag_scan_pp;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [9:0] in_data = '0;
  logic [1:0] in_mode = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [9:0] out_data;

  logic in4_valid = 1'b0, out4_ready = 1'b1;
  logic [11:0] in4_data = '0;
  logic [1:0] in4_mode = 2'b00;
  logic in4_ready, out4_valid, out4_last, busy4;
  logic [11:0] out4_data;

  zigzag_scan_pp #(.DATA_WIDTH(10), .LOG2_N(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));

  zigzag_scan_pp #(.DATA_WIDTH(12), .LOG2_N(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data), .in_mode(in4_mode),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data),
    .out_last(out4_last), .busy(busy4));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int zz8 [64] = '{0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,
                   40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,
                   29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,
                   47,55,62,63};
  int zz4 [16] = '{0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int perm8(input int mode, input int k);
    case (mode)
      0:       return zz8[k];
      2:       return (k % 8) * 8 + k / 8;
      default: return k;
    endcase
  endfunction

  logic [10:0] exp_q [$];
  int pop_cyc_q [$];
  int or_mode = 0;
  bit mon_en = 1'b1;
  bit stall_prev = 1'b0, prev_last = 1'b0, seen_vld = 1'b0;
  logic [9:0] prev_data = '0;
  int first_vld_cyc = 0, last_in_cyc = 0, n_last = 0;

  // Output monitor: chooses out_ready for the coming edge, then scores the beat.
  always @(negedge clk) begin
    logic [10:0] e;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (mon_en) begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[9:0]);
          chk("out_last", out_last, e[10]);
          pop_cyc_q.push_back(cyc);
          if (out_last) n_last++;
        end
      end
      if (out_valid && !seen_vld) begin
        seen_vld = 1'b1;
        first_vld_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_block(input int base, input int mode);
    logic [9:0] dv;
    logic l;
    for (int k = 0; k < 64; k++) begin
      dv = 10'(base + perm8(mode, k));
      l = (k == 63);
      exp_q.push_back({l, dv});
    end
  endtask

  task automatic send_block(input int base, input int mode, input bit gaps);
    int pos = 0, t = 0;
    bit acc;
    push_block(base, mode);
    while (pos < 64 && t < 20000) begin
      if (gaps && $urandom_range(0, 1) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data = 10'(base + pos);
        in_mode = 2'(mode);
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      t++;
      if (acc) begin pos++; last_in_cyc = cyc; end
    end
    in_valid = 1'b0;
    if (pos < 64) chk("send_timeout", pos, 64);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 10000) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, nl0, t, j, k;
    bit acc;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // zigzag block, latency from last input to first output
    seen_vld = 1'b0;
    send_block(0, 0, 1'b0);
    wait_drain();
    chk("t1_latency", first_vld_cyc - last_in_cyc, 2);

    // four back-to-back blocks in mixed modes
    pop_cyc_q.delete();
    send_block(100, 0, 1'b0);
    send_block(200, 1, 1'b0);
    send_block(300, 2, 1'b0);
    send_block(400, 0, 1'b0);
    wait_drain();
    chk("t2_count", pop_cyc_q.size(), 256);
    if (pop_cyc_q.size() == 256) begin
      chk("t2_boundary_gap", pop_cyc_q[64] - pop_cyc_q[63], 1);
      for (int b = 0; b < 4; b++)
        chk("t2_block_gapfree", pop_cyc_q[b*64+63] - pop_cyc_q[b*64], 63);
    end

    // output stalled: only two blocks fit
    #1 or_mode = 1;
    push_block(500, 2);
    push_block(600, 0);
    acc_n = 0;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_data = (acc_n < 64) ? 10'(500 + acc_n) : 10'(600 + (acc_n % 64));
      in_mode = (acc_n < 64) ? 2'b10 : 2'b00;
      acc = in_ready;
      @(negedge clk);
      if (acc) acc_n++;
    end
    in_valid = 1'b0;
    chk("t3_accepted", acc_n, 128);
    chk("t3_in_ready_low", in_ready, 0);
    chk("t3_busy", busy, 1);
    #1 or_mode = 0;
    nl0 = n_last;
    t = 0;
    while (n_last == nl0 && t < 500) begin @(negedge clk); #1; t++; end
    chk("t3_last_seen", n_last, nl0 + 1);
    chk("t3_rdy_at_last", in_ready, 0);
    @(negedge clk); #1;
    chk("t3_rdy_after_last", in_ready, 1);
    wait_drain();

    // random output back-pressure and input gaps
    #1 or_mode = 2;
    for (int b = 0; b < 20; b++)
      send_block((b * 37) % 900, int'($urandom_range(0, 3)), 1'b1);
    wait_drain();
    #1 or_mode = 0;

    // small block N=4
    j = 0; k = 0; t = 0;
    while (j < 16 && t < 100) begin
      in4_valid = (k < 16);
      in4_data = 12'(k);
      acc = in4_valid && in4_ready;
      if (out4_valid) begin
        chk("t5_data", out4_data, zz4[j]);
        chk("t5_last", out4_last, (j == 15));
        j++;
      end
      @(negedge clk);
      t++;
      if (acc) k++;
    end
    in4_valid = 1'b0;
    chk("t5_count", j, 16);

    // asynchronous reset with a partial block stored
    for (int p = 0; p < 30; p++) begin
      in_valid = 1'b1; in_data = 10'(900 + p); in_mode = 2'b01;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t6_busy_partial", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_block(700, 1, 1'b0);
    wait_drain();

    // flush while a block is draining
    #1 or_mode = 1;
    send_block(800, 0, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("t6_draining", out_valid, 1);
    #1 mon_en = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    chk("t6_flush_out_valid", out_valid, 0);
    chk("t6_flush_out_data", out_data, 0);
    chk("t6_flush_out_last", out_last, 0);
    chk("t6_flush_busy", busy, 0);
    chk("t6_flush_in_ready", in_ready, 1);
    @(negedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    or_mode = 0;
    @(negedge clk);
    send_block(900, 2, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
